spi_frame_receiver: RTL and testbench



---
 rtl/spi_frame_receiver_if.sv | 31 +++
 rtl/spi_frame_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_receiver_if.sv
// rtl/spi_frame_receiver_if.sv - SPI link pins between master and frame receiver
//
// Signals:
//   spi_clk  serial clock, idle low, driven by the master
//   mosi     serial data from the master, sampled on rising spi_clk
//   spi_ss   slave select, active low, driven by the master
//   miso     echo of the last sampled mosi bit, driven by the slave
// Modports:
//   master   drives spi_clk/mosi/spi_ss, receives miso
//   slave    receives spi_clk/mosi/spi_ss, drives miso

interface spi_frame_receiver_if;
    logic spi_clk;
    logic mosi;
    logic spi_ss;
    logic miso;

    modport master (
        output spi_clk,
        output mosi,
        output spi_ss,
        input  miso
    );

    modport slave (
        input  spi_clk,
        input  mosi,
        input  spi_ss,
        output miso
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// rtl/spi_frame_receiver.sv - oversampled SPI mode-0 slave that captures sin/cos result frames
//
// Captures FRAME_BITS-bit frames {pad, sin[FIELD_W-1:0], pad, cos[FIELD_W-1:0]},
// MSB first, framed by spi_ss low. spi_clk, mosi and spi_ss are resynchronised
// into clk and all decoding runs on the synchronised copies.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   spi         spi_frame_receiver_if.slave (spi_clk, mosi, spi_ss in; miso out)
//   rx_word     last good frame
//   fa_out_sin  sin field of the last good frame
//   fa_out_cos  cos field of the last good frame
//   rx_valid    one-cycle pulse: new good frame on the outputs
//   frame_err   one-cycle pulse: frame discarded (short, overrun, timeout, pad)
//   busy        high while a frame is being shifted in
//   pad_err     one-cycle pulse with frame_err when pad bits are non-zero
//               (port exists only when SPI_RX_PAD_CHECK_EN is defined)
//
// Build option: SPI_RX_PAD_CHECK_EN - reject correct-length frames whose pad bits are set.

module spi_frame_receiver #(
    parameter int FRAME_BITS  = 32,
    parameter int FIELD_W     = 14,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_frame_receiver_if.slave   spi,
    output logic [FRAME_BITS-1:0] rx_word,
    output logic [FIELD_W-1:0]    fa_out_sin,
    output logic [FIELD_W-1:0]    fa_out_cos,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
`ifdef SPI_RX_PAD_CHECK_EN
    ,
    output logic                  pad_err
`endif
);

    localparam int HALF   = FRAME_BITS / 2;
    localparam int CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Synchronisers; each resets to the idle level of its line.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    state_t                 state;
    logic [FRAME_BITS-1:0]  shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   last_bit;
    logic                   miso_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_clk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.spi_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    assign spi.miso  = miso_q;

`ifdef SPI_RX_PAD_CHECK_EN
    logic pad_bad;
    assign pad_bad = (|shreg[FRAME_BITS-1:HALF+FIELD_W]) | (|shreg[HALF-1:FIELD_W]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            last_bit   <= 1'b0;
            miso_q     <= 1'b0;
            rx_word    <= '0;
            fa_out_sin <= '0;
            fa_out_cos <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef SPI_RX_PAD_CHECK_EN
            pad_err    <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef SPI_RX_PAD_CHECK_EN
            pad_err   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    busy   <= 1'b0;
                    miso_q <= 1'b0;
                    if (ss_fall) begin
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                        shreg    <= '0;
                        bit_cnt  <= '0;
                        tmo_cnt  <= '0;
                        last_bit <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    // ss rise takes priority over a coincident spi_clk rise,
                    // so that last bit is never counted.
                    if (ss_rise) begin
                        state  <= ST_CHECK;
                        busy   <= 1'b0;
                        miso_q <= 1'b0;
                    end else if (sclk_rise) begin
                        // Past FRAME_BITS the word is frozen; the counter
                        // parks at FRAME_BITS+1 to mark the overrun.
                        if (bit_cnt < CNT_FULL) begin
                            shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
                        end
                        if (bit_cnt != CNT_OVR) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                        last_bit <= mosi_s;
                        tmo_cnt  <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt   <= tmo_cnt + TMO_W'(1);
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        miso_q    <= 1'b0;
                        frame_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (sclk_fall) begin
                            miso_q <= last_bit;
                        end
                    end
                end

                ST_CHECK: begin
                    state <= ST_IDLE;
`ifdef SPI_RX_PAD_CHECK_EN
                    if ((bit_cnt == CNT_FULL) && pad_bad) begin
                        frame_err <= 1'b1;
                        pad_err   <= 1'b1;
                    end else
`endif
                    if (bit_cnt == CNT_FULL) begin
                        rx_word    <= shreg;
                        fa_out_sin <= shreg[HALF+FIELD_W-1:HALF];
                        fa_out_cos <= shreg[FIELD_W-1:0];
                        rx_valid   <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb/tb_spi_frame_receiver.sv - scoreboard bench for spi_frame_receiver

module tb_spi_frame_receiver;

    localparam int TIMEOUT_CYC = 1023;

    logic        clk;
    logic        rst_n;
    logic [31:0] rx_word;
    logic [13:0] fa_out_sin;
    logic [13:0] fa_out_cos;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;
`ifdef SPI_RX_PAD_CHECK_EN
    logic        pad_err;
`endif

    spi_frame_receiver_if bus ();

    spi_frame_receiver #(
        .FRAME_BITS  (32),
        .FIELD_W     (14),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi        (bus.slave),
        .rx_word    (rx_word),
        .fa_out_sin (fa_out_sin),
        .fa_out_cos (fa_out_cos),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef SPI_RX_PAD_CHECK_EN
        ,
        .pad_err    (pad_err)
`endif
    );

    typedef struct {
        bit          is_valid;
        bit          pad;
        logic [31:0] word;
        logic [13:0] sin;
        logic [13:0] cos;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ss_rise_cyc = 0;
    int          last_rise_cyc = 0;
    int          last_err_cyc = 0;
    logic [31:0] last_good = 32'h0;

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_ok(input logic [31:0] w, input logic [13:0] s, input logic [13:0] c);
        exp_t e;
        e.is_valid = 1'b1;
        e.pad      = 1'b0;
        e.word     = w;
        e.sin      = s;
        e.cos      = c;
        exp_q.push_back(e);
        last_good = w;
    endtask

    task automatic push_err(input bit pad, input logic [13:0] s, input logic [13:0] c);
        exp_t e;
        e.is_valid = 1'b0;
        e.pad      = pad;
        e.word     = last_good;
        e.sin      = s;
        e.cos      = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every rx_valid / frame_err pulse is matched against the queue.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err)) begin
            exp_t e;
            check("pulse_exclusive", 32'(rx_valid & frame_err), 32'h0);
            if (frame_err) last_err_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: rx_valid=%0b frame_err=%0b", rx_valid, frame_err);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'(rx_valid), 32'(e.is_valid));
                check("rx_word", rx_word, e.word);
                check("fa_out_sin", 32'(fa_out_sin), 32'(e.sin));
                check("fa_out_cos", 32'(fa_out_cos), 32'(e.cos));
`ifdef SPI_RX_PAD_CHECK_EN
                check("pad_err", 32'(pad_err), 32'(e.pad));
`endif
                if (rx_valid) check("valid_latency", 32'(cyc - ss_rise_cyc), 32'd4);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.mosi = d[i];
            wait_clk(4);
            bus.spi_clk = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(4);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input logic [63:0] d, input int n);
        bus.spi_ss = 1'b0;
        wait_clk(4);
        send_bits(d, n);
        wait_clk(4);
        if (n > 0) check("miso_echo", 32'(bus.miso), 32'(d[0]));
        bus.spi_ss = 1'b1;
        ss_rise_cyc = cyc;
        wait_clk(12);
        bus.mosi = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_word"}, rx_word, 32'h0);
        check({tag, "_sin"}, 32'(fa_out_sin), 32'h0);
        check({tag, "_cos"}, 32'(fa_out_cos), 32'h0);
        check({tag, "_pulses"}, 32'({rx_valid, frame_err}), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_miso"}, 32'(bus.miso), 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.spi_clk = 1'b0;
        bus.mosi    = 1'b0;
        bus.spi_ss  = 1'b1;
        wait_clk(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_clk(4);

        // Good frame at spi_clk = clk/8.
        push_ok(32'h1ABC2DEF, 14'h1ABC, 14'h2DEF);
        frame(64'h1ABC2DEF, 32);

        // Short frame: 31 bits.
        push_err(1'b0, 14'h1ABC, 14'h2DEF);
        frame(64'h0D5E16F7, 31);

        // Overrun: 34 bits, first 32 are 0x1ABC2DEF.
        push_err(1'b0, 14'h1ABC, 14'h2DEF);
        frame({30'h0, 32'h1ABC2DEF, 2'b11}, 34);

        // Timeout: 5 bits then stall with ss low.
        push_err(1'b0, 14'h1ABC, 14'h2DEF);
        bus.spi_ss = 1'b0;
        wait_clk(4);
        send_bits(64'h15, 5);
        wait_clk(1100);
        check("timeout_delay", 32'(last_err_cyc - last_rise_cyc), 32'(TIMEOUT_CYC + 3));
        check("timeout_busy", 32'(busy), 32'h0);
        bus.spi_ss = 1'b1;
        wait_clk(12);

        push_ok(32'h00010002, 14'h0001, 14'h0002);
        frame(64'h00010002, 32);

        // Reset at bit 16 of a frame.
        bus.spi_ss = 1'b0;
        wait_clk(4);
        send_bits(64'h3FFF, 16);
        check("midframe_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        bus.spi_ss  = 1'b1;
        bus.mosi    = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        last_good = 32'h0;
        wait_clk(4);

        push_ok(32'h3FFF3FFF, 14'h3FFF, 14'h3FFF);
        frame(64'h3FFF3FFF, 32);

        // Pad bits set.
`ifdef SPI_RX_PAD_CHECK_EN
        push_err(1'b1, 14'h3FFF, 14'h3FFF);
`else
        push_ok(32'h8ABC2DEF, 14'h0ABC, 14'h2DEF);
`endif
        frame(64'h8ABC2DEF, 32);

        push_ok(32'h00003FFF, 14'h0000, 14'h3FFF);
        frame(64'h00003FFF, 32);

        wait_clk(20);
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
